// File: rtl/image_conv_pkg.sv
// ============================================================================
// Module : image_conv_pkg
// Brief  : Shared types and defaults for the image data converter datapath.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package image_conv_pkg;

   localparam int DATA_WIDTH_RAW_DEF = 16;

   typedef enum logic [1:0] {
      WAIT_SOF = 2'd0,
      EMPTY    = 2'd1,
      HALF     = 2'd2
   } pack_state_e;

endpackage

`default_nettype wire

// File: rtl/sat_counter.sv
// ============================================================================
// Module : sat_counter
// Brief  : Status counter that sticks at all-ones; cleared only by reset.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module sat_counter #(
   parameter int CNT_WIDTH = 16
) (
   input  logic                 aclk,
   input  logic                 aresetn,
   input  logic                 inc,
   output logic [CNT_WIDTH-1:0] count
);

   localparam logic [CNT_WIDTH-1:0] C_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

   logic [CNT_WIDTH-1:0] count_q;
   logic [CNT_WIDTH-1:0] count_d;

   always_comb begin
      count_d = count_q;
      if (inc && (count_q != '1)) begin
         count_d = count_q + C_ONE;
      end
   end

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count = count_q;

endmodule

`default_nettype wire

// File: rtl/raw_pair_packer.sv
// ============================================================================
// Module : raw_pair_packer
// Brief  : Pairs consecutive camera words into (first, second) tuples with
//          frame alignment, odd-line flushing and SOF resynchronisation.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module raw_pair_packer
   import image_conv_pkg::*;
#(
   parameter int DATA_WIDTH_RAW = DATA_WIDTH_RAW_DEF,
   parameter int CNT_WIDTH      = 16
) (
   input  logic                      aclk,
   input  logic                      aresetn,
   input  logic                      enable,
   input  logic [DATA_WIDTH_RAW-1:0] s_axis_tdata,
   input  logic                      s_axis_tvalid,
   output logic                      s_axis_tready,
   input  logic                      s_axis_tuser,
   input  logic                      s_axis_tlast,
   output logic                      pair_valid,
   input  logic                      pair_ready,
   output logic [DATA_WIDTH_RAW-1:0] DATA_OUT1,
   output logic [DATA_WIDTH_RAW-1:0] DATA_OUT2,
   output logic                      pair_sof,
   output logic                      pair_eol,
   output logic [CNT_WIDTH-1:0]      resync_cnt,
   output logic [CNT_WIDTH-1:0]      odd_line_cnt
);

   pack_state_e               state_q, state_d;
   logic [DATA_WIDTH_RAW-1:0] held_q, held_d;
   logic                      held_sof_q, held_sof_d;
   logic                      pair_valid_q, pair_valid_d;
   logic [DATA_WIDTH_RAW-1:0] data1_q, data1_d;
   logic [DATA_WIDTH_RAW-1:0] data2_q, data2_d;
   logic                      sof_q, sof_d;
   logic                      eol_q, eol_d;

   logic                      accept;
   logic                      load;
   logic [DATA_WIDTH_RAW-1:0] load_d1, load_d2;
   logic                      load_sof, load_eol;
   logic                      resync_inc, odd_inc;

   // Gated by reset so the slave port never advertises readiness during reset.
   assign s_axis_tready = aresetn & (~pair_valid_q | pair_ready);
   assign accept        = s_axis_tvalid & s_axis_tready;

   always_comb begin
      state_d    = state_q;
      held_d     = held_q;
      held_sof_d = held_sof_q;
      load       = 1'b0;
      load_d1    = '0;
      load_d2    = '0;
      load_sof   = 1'b0;
      load_eol   = 1'b0;
      resync_inc = 1'b0;
      odd_inc    = 1'b0;

      case (state_q)
         WAIT_SOF: begin
            if (accept && enable && s_axis_tuser) begin
               if (s_axis_tlast) begin
                  load     = 1'b1;
                  load_d1  = s_axis_tdata;
                  load_sof = 1'b1;
                  load_eol = 1'b1;
                  odd_inc  = 1'b1;
                  state_d  = EMPTY;
               end else begin
                  held_d     = s_axis_tdata;
                  held_sof_d = 1'b1;
                  state_d    = HALF;
               end
            end
         end

         EMPTY: begin
            if (!enable) begin
               state_d = WAIT_SOF;
            end else if (accept) begin
               if (s_axis_tlast) begin
                  load     = 1'b1;
                  load_d1  = s_axis_tdata;
                  load_sof = s_axis_tuser;
                  load_eol = 1'b1;
                  odd_inc  = 1'b1;
               end else begin
                  held_d     = s_axis_tdata;
                  held_sof_d = s_axis_tuser;
                  state_d    = HALF;
               end
            end
         end

         HALF: begin
            if (!enable) begin
               held_d     = '0;
               held_sof_d = 1'b0;
               state_d    = WAIT_SOF;
            end else if (accept) begin
               if (s_axis_tuser) begin
                  // A new frame started mid-pair: the held word is stale.
                  resync_inc = 1'b1;
                  if (s_axis_tlast) begin
                     load       = 1'b1;
                     load_d1    = s_axis_tdata;
                     load_sof   = 1'b1;
                     load_eol   = 1'b1;
                     odd_inc    = 1'b1;
                     held_d     = '0;
                     held_sof_d = 1'b0;
                     state_d    = EMPTY;
                  end else begin
                     held_d     = s_axis_tdata;
                     held_sof_d = 1'b1;
                  end
               end else begin
                  load       = 1'b1;
                  load_d1    = held_q;
                  load_d2    = s_axis_tdata;
                  load_sof   = held_sof_q;
                  load_eol   = s_axis_tlast;
                  held_d     = '0;
                  held_sof_d = 1'b0;
                  state_d    = EMPTY;
               end
            end
         end

         default: begin
            state_d = WAIT_SOF;
         end
      endcase
   end

   always_comb begin
      pair_valid_d = load | (pair_valid_q & ~pair_ready);
      data1_d      = data1_q;
      data2_d      = data2_q;
      sof_d        = sof_q;
      eol_d        = eol_q;
      if (load) begin
         data1_d = load_d1;
         data2_d = load_d2;
         sof_d   = load_sof;
         eol_d   = load_eol;
      end
   end

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         state_q      <= WAIT_SOF;
         held_q       <= '0;
         held_sof_q   <= 1'b0;
         pair_valid_q <= 1'b0;
         data1_q      <= '0;
         data2_q      <= '0;
         sof_q        <= 1'b0;
         eol_q        <= 1'b0;
      end else begin
         state_q      <= state_d;
         held_q       <= held_d;
         held_sof_q   <= held_sof_d;
         pair_valid_q <= pair_valid_d;
         data1_q      <= data1_d;
         data2_q      <= data2_d;
         sof_q        <= sof_d;
         eol_q        <= eol_d;
      end
   end

   sat_counter #(
      .CNT_WIDTH (CNT_WIDTH)
   ) u_resync_cnt (
      .aclk    (aclk),
      .aresetn (aresetn),
      .inc     (resync_inc),
      .count   (resync_cnt)
   );

   sat_counter #(
      .CNT_WIDTH (CNT_WIDTH)
   ) u_odd_line_cnt (
      .aclk    (aclk),
      .aresetn (aresetn),
      .inc     (odd_inc),
      .count   (odd_line_cnt)
   );

   assign pair_valid = pair_valid_q;
   assign DATA_OUT1  = data1_q;
   assign DATA_OUT2  = data2_q;
   assign pair_sof   = sof_q;
   assign pair_eol   = eol_q;

endmodule

`default_nettype wire

// File: tb/tb_raw_pair_packer.sv
// ============================================================================
// Module : tb_raw_pair_packer
// Brief  : Self-checking bench: directed vector table, corner sequences and a
//          randomized run against a transaction-level reference model.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_raw_pair_packer;

   localparam int DW   = 16;
   localparam int CW   = 4;
   localparam int CMAX = (1 << CW) - 1;

   logic          aclk = 1'b0;
   logic          aresetn = 1'b0;
   logic          enable = 1'b0;
   logic [DW-1:0] s_axis_tdata = '0;
   logic          s_axis_tvalid = 1'b0;
   logic          s_axis_tready;
   logic          s_axis_tuser = 1'b0;
   logic          s_axis_tlast = 1'b0;
   logic          pair_valid;
   logic          pair_ready = 1'b0;
   logic [DW-1:0] DATA_OUT1;
   logic [DW-1:0] DATA_OUT2;
   logic          pair_sof;
   logic          pair_eol;
   logic [CW-1:0] resync_cnt;
   logic [CW-1:0] odd_line_cnt;

   int vectors = 0;
   int miscompares = 0;

   always #5 aclk = ~aclk;

   raw_pair_packer #(
      .DATA_WIDTH_RAW (DW),
      .CNT_WIDTH      (CW)
   ) dut (
      .aclk          (aclk),
      .aresetn       (aresetn),
      .enable        (enable),
      .s_axis_tdata  (s_axis_tdata),
      .s_axis_tvalid (s_axis_tvalid),
      .s_axis_tready (s_axis_tready),
      .s_axis_tuser  (s_axis_tuser),
      .s_axis_tlast  (s_axis_tlast),
      .pair_valid    (pair_valid),
      .pair_ready    (pair_ready),
      .DATA_OUT1     (DATA_OUT1),
      .DATA_OUT2     (DATA_OUT2),
      .pair_sof      (pair_sof),
      .pair_eol      (pair_eol),
      .resync_cnt    (resync_cnt),
      .odd_line_cnt  (odd_line_cnt)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model (word-level rules, queue for held word)
   typedef struct {
      logic [DW-1:0] w;
      bit            sof;
   } hw_t;

   bit            m_synced;
   hw_t           m_held[$];
   bit            m_pv;
   logic [DW-1:0] m_d1, m_d2;
   bit            m_sof, m_eol;
   int            m_resync, m_odd;

   task automatic model_reset();
      m_synced = 0;
      m_held.delete();
      m_pv = 0; m_d1 = '0; m_d2 = '0; m_sof = 0; m_eol = 0;
      m_resync = 0; m_odd = 0;
   endtask

   task automatic model_step();
      bit            acc, ld, ls, le;
      logic [DW-1:0] l1, l2;
      hw_t           h;
      acc = s_axis_tvalid && (!m_pv || pair_ready);
      ld = 0; ls = 0; le = 0; l1 = '0; l2 = '0;
      if (!m_synced) begin
         if (acc && enable && s_axis_tuser) begin
            m_synced = 1;
            if (s_axis_tlast) begin
               ld = 1; l1 = s_axis_tdata; ls = 1; le = 1;
               if (m_odd < CMAX) m_odd++;
            end else begin
               h.w = s_axis_tdata; h.sof = 1; m_held.push_back(h);
            end
         end
      end else if (!enable) begin
         m_synced = 0;
         m_held.delete();
      end else if (acc) begin
         if (m_held.size() == 0) begin
            if (s_axis_tlast) begin
               ld = 1; l1 = s_axis_tdata; ls = s_axis_tuser; le = 1;
               if (m_odd < CMAX) m_odd++;
            end else begin
               h.w = s_axis_tdata; h.sof = s_axis_tuser; m_held.push_back(h);
            end
         end else if (s_axis_tuser) begin
            if (m_resync < CMAX) m_resync++;
            m_held.delete();
            if (s_axis_tlast) begin
               ld = 1; l1 = s_axis_tdata; ls = 1; le = 1;
               if (m_odd < CMAX) m_odd++;
            end else begin
               h.w = s_axis_tdata; h.sof = 1; m_held.push_back(h);
            end
         end else begin
            h = m_held.pop_front();
            ld = 1; l1 = h.w; l2 = s_axis_tdata; ls = h.sof; le = s_axis_tlast;
         end
      end
      if (ld) begin
         m_pv = 1; m_d1 = l1; m_d2 = l2; m_sof = ls; m_eol = le;
      end else if (pair_ready) begin
         m_pv = 0;
      end
   endtask

   // ---------------- directed vector table
   typedef struct {
      logic          en, v;
      logic [DW-1:0] d;
      logic          u, l, rdy;
      logic          e_trdy, e_pv;
      logic [DW-1:0] e1, e2;
      logic          es, ee;
   } vec_t;

   vec_t tbl[17];

   task automatic drive(input logic en, input logic v, input logic [DW-1:0] d,
                        input logic u, input logic l, input logic rdy);
      enable = en; s_axis_tvalid = v; s_axis_tdata = d;
      s_axis_tuser = u; s_axis_tlast = l; pair_ready = rdy;
   endtask

   task automatic do_reset();
      aresetn = 1'b0;
      drive(0, 0, '0, 0, 0, 0);
      repeat (2) @(negedge aclk);
      chk("rst_tready", s_axis_tready, 0);
      chk("rst_outs", {pair_valid, DATA_OUT1, DATA_OUT2, pair_sof, pair_eol}, 0);
      chk("rst_cnts", {resync_cnt, odd_line_cnt}, 0);
      aresetn = 1'b1;
      model_reset();
   endtask

   initial begin
      logic [DW-1:0] words[8];
      logic [DW-1:0] got1[$], got2[$];
      logic [2*DW-1:0] snap;
      int idx, stall_left, cyc;
      bit stalled;

      //        en v  d        u  l  rdy trdy pv  e1       e2       s  e
      tbl[0]  = '{1, 1, 16'h1111, 1, 0, 1, 1, 0, 16'h0000, 16'h0000, 0, 0};
      tbl[1]  = '{1, 1, 16'h2222, 0, 1, 1, 1, 1, 16'h1111, 16'h2222, 1, 1};
      tbl[2]  = '{1, 0, 16'h0000, 0, 0, 1, 1, 0, 16'h0000, 16'h0000, 0, 0};
      tbl[3]  = '{0, 0, 16'h0000, 0, 0, 1, 1, 0, 16'h0000, 16'h0000, 0, 0};
      tbl[4]  = '{1, 1, 16'hAAAA, 0, 0, 1, 1, 0, 16'h0000, 16'h0000, 0, 0};
      tbl[5]  = '{1, 1, 16'hBBBB, 0, 0, 1, 1, 0, 16'h0000, 16'h0000, 0, 0};
      tbl[6]  = '{1, 1, 16'h0001, 1, 0, 1, 1, 0, 16'h0000, 16'h0000, 0, 0};
      tbl[7]  = '{1, 1, 16'h0002, 0, 1, 1, 1, 1, 16'h0001, 16'h0002, 1, 1};
      tbl[8]  = '{1, 0, 16'h0000, 0, 0, 1, 1, 0, 16'h0000, 16'h0000, 0, 0};
      tbl[9]  = '{1, 1, 16'h0010, 1, 0, 1, 1, 0, 16'h0000, 16'h0000, 0, 0};
      tbl[10] = '{1, 1, 16'h0020, 0, 0, 1, 1, 1, 16'h0010, 16'h0020, 1, 0};
      tbl[11] = '{1, 1, 16'h0030, 0, 1, 1, 1, 1, 16'h0030, 16'h0000, 0, 1};
      tbl[12] = '{1, 0, 16'h0000, 0, 0, 1, 1, 0, 16'h0000, 16'h0000, 0, 0};
      tbl[13] = '{1, 1, 16'h0100, 1, 0, 1, 1, 0, 16'h0000, 16'h0000, 0, 0};
      tbl[14] = '{1, 1, 16'h0200, 1, 0, 1, 1, 0, 16'h0000, 16'h0000, 0, 0};
      tbl[15] = '{1, 1, 16'h0300, 0, 0, 1, 1, 1, 16'h0200, 16'h0300, 1, 0};
      tbl[16] = '{1, 0, 16'h0000, 0, 0, 1, 1, 0, 16'h0000, 16'h0000, 0, 0};

      do_reset();
      for (int i = 0; i < 17; i++) begin
         drive(tbl[i].en, tbl[i].v, tbl[i].d, tbl[i].u, tbl[i].l, tbl[i].rdy);
         #1;
         chk($sformatf("tbl%0d_tready", i), s_axis_tready, tbl[i].e_trdy);
         @(negedge aclk);
         chk($sformatf("tbl%0d_pv", i), pair_valid, tbl[i].e_pv);
         if (tbl[i].e_pv)
            chk($sformatf("tbl%0d_pair", i), {DATA_OUT1, DATA_OUT2},
                {tbl[i].e1, tbl[i].e2});
         if (tbl[i].e_pv)
            chk($sformatf("tbl%0d_flags", i), {pair_sof, pair_eol}, {tbl[i].es, tbl[i].ee});
      end
      chk("tbl_odd_cnt", odd_line_cnt, 1);
      chk("tbl_resync_cnt", resync_cnt, 1);

      // ---------------- backpressure over an 8-word line
      do_reset();
      for (int i = 0; i < 8; i++) words[i] = 16'(16'h3000 + i * 16'h0111);
      idx = 0; stall_left = 0; stalled = 0; cyc = 0;
      while (got1.size() < 4 && cyc < 60) begin
         if (!stalled && pair_valid) begin
            stalled = 1; stall_left = 5; snap = {DATA_OUT1, DATA_OUT2};
         end
         drive(1, idx < 8, (idx < 8) ? words[idx] : '0, idx == 0, idx == 7, stall_left == 0);
         #1;
         if (stall_left > 0) begin
            chk("bp_tready_low", s_axis_tready, 0);
            chk("bp_hold", {DATA_OUT1, DATA_OUT2}, snap);
            stall_left--;
         end
         if (pair_valid && pair_ready) begin
            got1.push_back(DATA_OUT1); got2.push_back(DATA_OUT2);
         end
         if (s_axis_tvalid && s_axis_tready) idx++;
         @(negedge aclk);
         cyc++;
      end
      chk("bp_pair_count", got1.size(), 4);
      for (int p = 0; p < 4; p++) begin
         if (p < got1.size()) begin
            chk($sformatf("bp_pair%0d", p), {got1[p], got2[p]}, {words[2*p], words[2*p+1]});
         end
      end

      // ---------------- enable drop in HALF, then asynchronous reset mid-line
      do_reset();
      drive(1, 1, 16'h1234, 1, 1, 1); @(negedge aclk);
      chk("sof_odd_pair", {pair_valid, DATA_OUT1, DATA_OUT2, pair_sof, pair_eol},
          {1'b1, 16'h1234, 16'h0000, 1'b1, 1'b1});
      chk("sof_odd_cnt", odd_line_cnt, 1);
      drive(1, 1, 16'h5555, 1, 0, 1); @(negedge aclk);
      drive(0, 1, 16'h6666, 0, 0, 1); @(negedge aclk);
      chk("en_off_pv", pair_valid, 0);
      drive(1, 1, 16'h7777, 0, 1, 1); @(negedge aclk);
      chk("en_nosof_pv", pair_valid, 0);
      drive(1, 0, 16'h0000, 0, 0, 1); @(negedge aclk);
      chk("en_idle_pv", pair_valid, 0);
      drive(1, 1, 16'h8888, 1, 0, 1); @(negedge aclk);
      drive(1, 1, 16'h9999, 0, 1, 0); @(negedge aclk);
      chk("en_resume_pair", {pair_valid, DATA_OUT1, DATA_OUT2, pair_sof, pair_eol},
          {1'b1, 16'h8888, 16'h9999, 1'b1, 1'b1});
      chk("en_resync_none", resync_cnt, 0);
      drive(1, 1, 16'hAAAA, 1, 0, 0);
      #2 aresetn = 1'b0;
      #1;
      chk("async_rst_outs", {pair_valid, DATA_OUT1, DATA_OUT2, pair_sof, pair_eol}, 0);
      chk("async_rst_tready", s_axis_tready, 0);
      chk("async_rst_cnts", {resync_cnt, odd_line_cnt}, 0);
      @(negedge aclk);
      aresetn = 1'b1;
      model_reset();

      // ---------------- randomized run against the reference model
      for (int c = 0; c < 2500; c++) begin
         drive($urandom_range(0, 31) != 0, $urandom_range(0, 3) != 0, 16'($urandom),
               $urandom_range(0, 7) == 0, $urandom_range(0, 5) == 0,
               $urandom_range(0, 3) != 0);
         #1;
         chk("rnd_tready", s_axis_tready, !m_pv || pair_ready);
         model_step();
         @(negedge aclk);
         chk("rnd_pv", pair_valid, m_pv);
         if (m_pv)
            chk("rnd_pair", {DATA_OUT1, DATA_OUT2, pair_sof, pair_eol},
                {m_d1, m_d2, m_sof, m_eol});
         chk("rnd_cnts", {resync_cnt, odd_line_cnt}, {CW'(m_resync), CW'(m_odd)});
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

`default_nettype wire
